// File: rtl/pattern_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Build option: PATTERN_DETECT_CNT_EN adds the saturating match counter.
package pattern_detect_pkg;

    localparam int W_DEF     = 8;
    localparam int CNT_W_DEF = 16;
    localparam int MAX_W     = 64;
    localparam int LEN_W     = $clog2(MAX_W + 1);

    typedef struct packed {
        logic [MAX_W-1:0] pattern;
        logic [MAX_W-1:0] mask;
        logic [LEN_W-1:0] len;
        logic             overlap;
    } cfg_t;

    // Power-on config: the legacy fixed 8-bit overlapping detector.
    localparam cfg_t CFG_DEF = '{
        pattern: MAX_W'(8'b1001_1010),
        mask:    MAX_W'({W_DEF{1'b1}}),
        len:     LEN_W'(W_DEF),
        overlap: 1'b1
    };

    function automatic logic [MAX_W-1:0] calc_emask(
        input logic [MAX_W-1:0] mask,
        input logic [LEN_W-1:0] len
    );
        logic [MAX_W-1:0] len_mask;
        if (len >= LEN_W'(MAX_W)) begin
            len_mask = '1;
        end else begin
            len_mask = (MAX_W'(1) << len) - MAX_W'(1);
        end
        return mask & len_mask;
    endfunction

endpackage

// File: rtl/pattern_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Only instantiated when PATTERN_DETECT_CNT_EN is defined.
module sat_counter
    import pattern_detect_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pattern_detect.sv
// Runtime-programmable serial pattern detector with mask, length and overlap mode.
// Build option: PATTERN_DETECT_CNT_EN builds the match counter; otherwise match_cnt_r is 0.
module pattern_detect
    import pattern_detect_pkg::*;
#(
    parameter int             W           = W_DEF,
    parameter int             CNT_W       = CNT_W_DEF,
    parameter logic [W-1:0]   PATTERN_DEF = W'(8'b1001_1010)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic                       in,
    input  logic                       cfg_vld,
    input  logic [W-1:0]               cfg_pattern,
    input  logic [W-1:0]               cfg_mask,
    input  logic [$clog2(W+1)-1:0]     cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cnt_clr,
    output logic                       match_r,
    output logic [CNT_W-1:0]           match_cnt_r
);

    localparam int LW = $clog2(W + 1);

    logic [W-1:0]  pat_r;
    logic [W-1:0]  mask_r;
    logic [LW-1:0] len_r;
    logic          ovl_r;

    logic [W-1:0]  shift_r;
    logic [LW-1:0] fill_r;

    logic [W-1:0]  nxt;
    logic [W-1:0]  emask;
    logic [LW-1:0] len_in;
    logic [LW:0]   fill_p1;
    logic [LW-1:0] fill_inc;
    logic          hit;

    assign len_in   = (cfg_len > LW'(W)) ? LW'(W) : cfg_len;
    assign emask    = W'(calc_emask(MAX_W'(mask_r), LEN_W'(len_r)));
    assign nxt      = {shift_r[W-2:0], in};
    assign fill_p1  = {1'b0, fill_r} + (LW+1)'(1);
    assign fill_inc = (fill_r == LW'(W)) ? fill_r : fill_p1[LW-1:0];

    // fill_p1 counts the incoming bit so a window is complete on its len-th bit.
    assign hit = (len_r != '0)
              && (fill_p1 >= {1'b0, len_r})
              && ((nxt & emask) == (pat_r & emask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r  <= PATTERN_DEF;
            mask_r <= '1;
            len_r  <= LW'(W);
            ovl_r  <= 1'b1;
        end else if (cfg_vld) begin
            pat_r  <= cfg_pattern;
            mask_r <= cfg_mask;
            len_r  <= len_in;
            ovl_r  <= cfg_overlap;
        end
    end

    // A config load restarts the stream; any bit offered in the same cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
        end else if (cfg_vld) begin
            shift_r <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
        end else if (in_vld) begin
            shift_r <= nxt;
            match_r <= hit;
            fill_r  <= (hit && !ovl_r) ? '0 : fill_inc;
        end else begin
            match_r <= 1'b0;
        end
    end

`ifdef PATTERN_DETECT_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_r),
        .clr   (cnt_clr | cfg_vld),
        .cnt   (match_cnt_r)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt_r    = '0;
`endif

endmodule

// File: tb/tb_pattern_detect.sv
// Self-checking bench for pattern_detect: directed vector table, corner sequences, random vs model.
module tb_pattern_detect;

    localparam int W     = 8;
    localparam int CNT_W = 2;
    localparam int LW    = $clog2(W + 1);
`ifdef PATTERN_DETECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in = 1'b0;
    logic          cfg_vld = 1'b0;
    logic [W-1:0]  cfg_pattern = '0;
    logic [W-1:0]  cfg_mask = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          match_r;
    logic [CNT_W-1:0] match_cnt_r;

    always #5 clk = ~clk;

    pattern_detect #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in          (in),
        .cfg_vld     (cfg_vld),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match_r     (match_r),
        .match_cnt_r (match_cnt_r)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: history of accepted bits, newest at index 0.
    bit           em;
    int           ecnt;
    bit           hist[$];
    logic [W-1:0] mpat;
    logic [W-1:0] mmask;
    int           mlen;
    bit           movl;

    function automatic void model_reset();
        em   = 1'b0;
        ecnt = 0;
        hist.delete();
        mpat  = 8'b1001_1010;
        mmask = '1;
        mlen  = W;
        movl  = 1'b1;
    endfunction

    function automatic void model_edge(input bit v, input bit d, input bit cv, input bit clr);
        bit old_m;
        bit hit;
        old_m = em;
        if (cv) begin
            mpat  = cfg_pattern;
            mmask = cfg_mask;
            mlen  = (int'(cfg_len) > W) ? W : int'(cfg_len);
            movl  = cfg_overlap;
            hist.delete();
            em   = 1'b0;
            ecnt = 0;
            return;
        end
        if (v) begin
            hist.push_front(d);
            if (hist.size() > W) void'(hist.pop_back());
            hit = (mlen != 0) && (hist.size() >= mlen);
            if (hit) begin
                for (int i = 0; i < mlen; i++) begin
                    if (mmask[i] && (hist[i] != mpat[i])) hit = 1'b0;
                end
            end
            em = hit;
            if (hit && !movl) hist.delete();
        end else begin
            em = 1'b0;
        end
        if (CNT_EN) begin
            if (clr) ecnt = 0;
            else if (old_m && ecnt < (1 << CNT_W) - 1) ecnt++;
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input bit v, input bit d, input bit cv, input bit clr);
        in_vld  = v;
        in      = d;
        cfg_vld = cv;
        cnt_clr = clr;
        @(posedge clk);
        model_edge(v, d, cv, clr);
        #1;
        check("model_match", 32'(match_r), 32'(em));
        check("model_cnt", 32'(match_cnt_r), 32'(ecnt));
    endtask

    typedef struct {
        bit            load;
        logic [W-1:0]  pat;
        logic [W-1:0]  mask;
        logic [LW-1:0] len;
        bit            ovl;
        bit            vld;
        bit            din;
        bit            exp_m;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_cfg(input logic [W-1:0] p, input logic [W-1:0] m,
                                    input logic [LW-1:0] l, input bit o, input bit v);
        tbl.push_back('{1'b1, p, m, l, o, v, 1'b1, 1'b0});
    endfunction

    function automatic void add_bits(input int n, input logic [15:0] bits, input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            tbl.push_back('{1'b0, '0, '0, '0, 1'b0, 1'b1, bits[n-1-i], exp[n-1-i]});
        end
    endfunction

    task automatic run_table(input string nm);
        foreach (tbl[k]) begin
            if (tbl[k].load) begin
                cfg_pattern = tbl[k].pat;
                cfg_mask    = tbl[k].mask;
                cfg_len     = tbl[k].len;
                cfg_overlap = tbl[k].ovl;
            end
            tick(tbl[k].vld, tbl[k].din, tbl[k].load, 1'b0);
            check(nm, 32'(match_r), 32'(tbl[k].exp_m));
        end
        tbl.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_match", 32'(match_r), 32'd0);
        check("reset_cnt", 32'(match_cnt_r), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset defaults: legacy 10011010 overlapping detector.
        add_bits(8, 16'b1001_1010, 16'b0000_0001);
        add_bits(6, 16'b01_1010, 16'b00_0001);
        run_table("default_seq");
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("default_cnt", 32'(match_cnt_r), CNT_EN ? 32'd2 : 32'd0);

        // Short length, overlap off/on; don't-care mask; len 0; len clamp; coincident load.
        add_cfg(8'b101, 8'b111, 4'd3, 1'b0, 1'b0);
        add_bits(5, 16'b10101, 16'b00100);
        add_cfg(8'b101, 8'b111, 4'd3, 1'b1, 1'b0);
        add_bits(5, 16'b10101, 16'b00101);
        add_cfg(8'b1001, 8'b1011, 4'd4, 1'b1, 1'b0);
        add_bits(4, 16'b1001, 16'b0001);
        add_cfg(8'b1001, 8'b1011, 4'd4, 1'b1, 1'b0);
        add_bits(4, 16'b1101, 16'b0001);
        add_cfg(8'b1001, 8'b1011, 4'd4, 1'b1, 1'b0);
        add_bits(4, 16'b1000, 16'b0000);
        add_cfg(8'b1001_1010, 8'hFF, 4'd0, 1'b1, 1'b0);
        add_bits(8, 16'b1001_1010, 16'b0);
        add_bits(8, 16'b0000_0000, 16'b0);
        add_cfg(8'b1001_1010, 8'hFF, 4'(W + 5), 1'b1, 1'b0);
        add_bits(8, 16'b1001_1010, 16'b0000_0001);
        add_cfg(8'b1001_1010, 8'hFF, 4'd8, 1'b1, 1'b1);
        add_bits(7, 16'b001_1010, 16'b0);
        run_table("cfg_seq");
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("coincident_cnt", 32'(match_cnt_r), 32'd0);

        // Counter saturation and clear-beats-increment.
        cfg_pattern = 8'b1; cfg_mask = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_cnt", 32'(match_cnt_r), CNT_EN ? 32'd3 : 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_clr_match", 32'(match_r), 32'd1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_vs_inc_cnt", 32'(match_cnt_r), 32'd0);

        // Async reset between edges while a match pulse is high.
        cfg_pattern = 8'b1001_1010; cfg_mask = 8'hFF; cfg_len = 4'd8; cfg_overlap = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) tick(1'b1, 1'(8'b1001_1010 >> i), 1'b0, 1'b0);
        check("pre_reset_match", 32'(match_r), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_match", 32'(match_r), 32'd0);
        check("async_cnt", 32'(match_cnt_r), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        add_bits(6, 16'b01_1010, 16'b0);
        add_bits(8, 16'b1001_1010, 16'b0000_0001);
        run_table("post_reset_seq");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cfg_pattern = W'($urandom);
                cfg_mask    = W'($urandom | $urandom);
                cfg_len     = LW'($urandom_range(0, 12));
                cfg_overlap = 1'($urandom);
                tick(1'($urandom), 1'($urandom), 1'b1, 1'b0);
            end else begin
                tick(r < 75, 1'($urandom), 1'b0, r > 95);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
